// File: rtl/timebase_ctrl.sv
// Horizontal timebase controller: turns up/down button levels into a
// saturating scale index with press-step and hold-to-repeat, and paces ADC
// capture with a one-cycle sample strobe whose period follows the scale.
module timebase_ctrl #(
  parameter int unsigned CLK_NS          = 10,
  parameter int unsigned SAMPLES_PER_DIV = 100,
  parameter int unsigned DEFAULT_SCALE   = 9,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        run,
  output logic [3:0]  scale_out,
  output logic        scale_changed,
  output logic        sample_tick,
  output logic [13:0] tick_period
);

  // Clocks per capture sample at one ns of time/div resolution.
  localparam int unsigned DIV = CLK_NS * SAMPLES_PER_DIV;

  localparam logic [3:0] MAX_SCALE = 4'd12;

  // Time/div in ns for each scale index.
  localparam int unsigned TIME_NS [13] = '{
    1000, 2000, 5000, 10000, 20000, 50000, 100000,
    200000, 500000, 1000000, 2000000, 5000000, 10000000
  };

  // Strobe period per scale index, fixed at elaboration.
  localparam logic [13:0] PERIOD_TBL [13] = '{
    14'(TIME_NS[0]  / DIV), 14'(TIME_NS[1]  / DIV), 14'(TIME_NS[2]  / DIV),
    14'(TIME_NS[3]  / DIV), 14'(TIME_NS[4]  / DIV), 14'(TIME_NS[5]  / DIV),
    14'(TIME_NS[6]  / DIV), 14'(TIME_NS[7]  / DIV), 14'(TIME_NS[8]  / DIV),
    14'(TIME_NS[9]  / DIV), 14'(TIME_NS[10] / DIV), 14'(TIME_NS[11] / DIV),
    14'(TIME_NS[12] / DIV)
  };

  localparam logic [3:0]  RESET_SCALE  = 4'(DEFAULT_SCALE);
  localparam logic [25:0] HOLD_LAST    = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] REPEAT_LAST  = 26'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_HOLD,
    ST_REPEAT
  } state_e;

  typedef enum logic {
    DIR_DOWN,
    DIR_UP
  } dir_e;

  // Table lookup; indices past the top of the table read as the slowest period.
  function automatic logic [13:0] period_of(input logic [3:0] idx);
    logic [13:0] p;
    p = PERIOD_TBL[12];
    for (int i = 0; i < 13; i++) begin
      if (idx == 4'(i)) p = PERIOD_TBL[i];
    end
    return p;
  endfunction

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [25:0] hold_q, hold_d;
  logic        step;
  logic        released;

  logic [3:0]  scale_q, scale_d;
  logic        changed;
  logic        changed_q;
  logic [13:0] period_q;

  logic [13:0] tick_cnt_q;
  logic        tick_q;

  // Button FSM next-state: press steps once, long hold enters auto-repeat.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    step    = 1'b0;
    // The latched button let go, or the opposite one joined in.
    released = (dir_q == DIR_UP) ? (!btn_up || btn_down) : (!btn_down || btn_up);

    case (state_q)
      ST_IDLE: begin
        if (btn_up ^ btn_down) begin
          step    = 1'b1;
          dir_d   = btn_up ? DIR_UP : DIR_DOWN;
          hold_d  = '0;
          state_d = ST_WAIT_HOLD;
        end
      end
      ST_WAIT_HOLD: begin
        if (released) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          step    = 1'b1;
          hold_d  = '0;
          state_d = ST_REPEAT;
        end else begin
          hold_d = hold_q + 26'd1;
        end
      end
      ST_REPEAT: begin
        if (released) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else if (hold_q == REPEAT_LAST) begin
          step   = 1'b1;
          hold_d = '0;
        end else begin
          hold_d = hold_q + 26'd1;
        end
      end
      default: begin
        hold_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating scale step; a step that hits a limit leaves the value alone.
  always_comb begin
    scale_d = scale_q;
    if (step) begin
      if (dir_d == DIR_UP) begin
        if (scale_q < MAX_SCALE) scale_d = scale_q + 4'd1;
      end else begin
        if (scale_q != 4'd0) scale_d = scale_q - 4'd1;
      end
    end
    changed = (scale_d != scale_q);
  end

  // Button FSM, scale index and its derived strobe period.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      hold_q    <= '0;
      scale_q   <= RESET_SCALE;
      changed_q <= 1'b0;
      period_q  <= period_of(RESET_SCALE);
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      hold_q    <= hold_d;
      scale_q   <= scale_d;
      changed_q <= changed;
      period_q  <= period_of(scale_d);
    end
  end

  // Sample strobe: one pulse per period; a scale change restarts the count so
  // the cycle showing scale_changed has a zero count and no strobe.
  always_ff @(posedge clk) begin
    if (rst || !run || changed) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (tick_cnt_q >= period_q - 14'd1) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + 14'd1;
      tick_q     <= 1'b0;
    end
  end

  assign scale_out     = scale_q;
  assign scale_changed = changed_q;
  assign sample_tick   = tick_q;
  assign tick_period   = period_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Directed bench for timebase_ctrl with short hold/repeat times. Inputs are
// driven and outputs sampled on the falling edge.
module tb_timebase_ctrl;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up;
  logic        btn_down;
  logic        run;
  logic [3:0]  scale_out;
  logic        scale_changed;
  logic        sample_tick;
  logic [13:0] tick_period;

  int checks = 0;
  int errors = 0;

  timebase_ctrl #(
    .CLK_NS          (10),
    .SAMPLES_PER_DIV (100),
    .DEFAULT_SCALE   (9),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .run           (run),
    .scale_out     (scale_out),
    .scale_changed (scale_changed),
    .sample_tick   (sample_tick),
    .tick_period   (tick_period)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  up;
    logic  down;
    int    scale;
    int    changed;
    int    period;
    string name;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive buttons and run n cycles, counting scale_changed pulses seen.
  task automatic hold_btn(input logic up, input logic down, input int n, output int pulses);
    btn_up   = up;
    btn_down = down;
    pulses   = 0;
    repeat (n) begin
      @(negedge clk);
      pulses += int'(scale_changed);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, nticks, pulses, p2, expv;

    vecs[0] = '{1'b1, 1'b1, 10, 0, 2000, "both_idle"};
    vecs[1] = '{1'b0, 1'b0, 10, 0, 2000, "none"};
    vecs[2] = '{1'b0, 1'b1,  9, 1, 1000, "down_press"};
    vecs[3] = '{1'b1, 1'b1,  9, 0, 1000, "other_joins"};
    vecs[4] = '{1'b1, 1'b1,  9, 0, 1000, "both_stay"};
    vecs[5] = '{1'b0, 1'b1,  8, 1,  500, "down_again"};
    vecs[6] = '{1'b0, 1'b0,  8, 0,  500, "release1"};
    vecs[7] = '{1'b1, 1'b0,  9, 1, 1000, "up_press"};
    vecs[8] = '{1'b0, 1'b0,  9, 0, 1000, "release2"};

    // Reset state.
    rst = 1'b1; run = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scale", int'(scale_out), 9);
    check("rst_period", int'(tick_period), 1000);
    check("rst_tick", int'(sample_tick), 0);
    check("rst_changed", int'(scale_changed), 0);

    // Strobe every 1000 clocks, first one 1000 edges after reset release.
    rst = 1'b0;
    first = -1; second = -1; nticks = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (sample_tick) begin
        nticks++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check("tick_first", first, 1000);
    check("tick_second", second, 2000);
    check("tick_count", nticks, 2);

    // Single step: up held 3 cycles, then count to the first new strobe.
    btn_up = 1'b1;
    @(negedge clk);
    check("step_scale", int'(scale_out), 10);
    check("step_changed", int'(scale_changed), 1);
    check("step_period", int'(tick_period), 2000);
    check("step_tick", int'(sample_tick), 0);
    pulses = int'(scale_changed);
    @(negedge clk);
    pulses += int'(scale_changed);
    @(negedge clk);
    pulses += int'(scale_changed);
    btn_up = 1'b0;
    first = -1;
    for (int k = 3; k <= 2500 && first < 0; k++) begin
      @(negedge clk);
      pulses += int'(scale_changed);
      if (sample_tick) first = k;
    end
    check("step_pulses", pulses, 1);
    check("step_tick_restart", first, 2000);
    check("step_hold_scale", int'(scale_out), 10);

    // Conflict and re-press table.
    foreach (vecs[i]) begin
      btn_up   = vecs[i].up;
      btn_down = vecs[i].down;
      @(negedge clk);
      check({vecs[i].name, "_scale"}, int'(scale_out), vecs[i].scale);
      check({vecs[i].name, "_changed"}, int'(scale_changed), vecs[i].changed);
      check({vecs[i].name, "_period"}, int'(tick_period), vecs[i].period);
    end

    // Auto-repeat down from 9: steps on edges t, t+8, t+12, ... t+24.
    btn_down = 1'b1;
    pulses = 0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      pulses += int'(scale_changed);
      expv = (i < HOLD) ? 8 : 7 - (i - HOLD) / REP;
      check($sformatf("repeat_scale_%0d", i), int'(scale_out), expv);
    end
    hold_btn(1'b0, 1'b0, 12, p2);
    check("repeat_pulses", pulses, 6);
    check("repeat_no_extra", p2, 0);
    check("repeat_final", int'(scale_out), 3);

    // Tap up to 11, then hold up into saturation.
    for (int i = 0; i < 8; i++) begin
      hold_btn(1'b1, 1'b0, 1, p2);
      hold_btn(1'b0, 1'b0, 1, p2);
    end
    check("tap_scale", int'(scale_out), 11);
    hold_btn(1'b1, 1'b0, 20, pulses);
    check("sat_up_pulses", pulses, 1);
    check("sat_up_scale", int'(scale_out), 12);
    check("sat_up_period", int'(tick_period), 10000);
    hold_btn(1'b0, 1'b0, 2, p2);

    // Down from 12 to 1 by auto-repeat (11 steps), then saturate at 0.
    hold_btn(1'b0, 1'b1, 45, pulses);
    hold_btn(1'b0, 1'b0, 2, p2);
    check("walk_down_pulses", pulses, 11);
    check("walk_down_scale", int'(scale_out), 1);
    hold_btn(1'b0, 1'b1, 20, pulses);
    check("sat_dn_pulses", pulses, 1);
    check("sat_dn_scale", int'(scale_out), 0);
    check("sat_dn_period", int'(tick_period), 1);
    hold_btn(1'b0, 1'b0, 2, p2);

    // Freeze, then P=1 strobe every cycle.
    run = 1'b0;
    nticks = 0;
    repeat (50) begin
      @(negedge clk);
      nticks += int'(sample_tick);
    end
    check("freeze_ticks", nticks, 0);
    run = 1'b1;
    @(negedge clk);
    check("p1_first", int'(sample_tick), 1);
    nticks = 0;
    repeat (10) begin
      @(negedge clk);
      nticks += int'(sample_tick);
    end
    check("p1_every_cycle", nticks, 10);

    // Reset during REPEAT with up held.
    hold_btn(1'b1, 1'b0, 10, pulses);
    check("pre_rst_scale", int'(scale_out), 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_scale", int'(scale_out), 9);
    check("mid_rst_changed", int'(scale_changed), 0);
    check("mid_rst_period", int'(tick_period), 1000);
    @(negedge clk);
    check("mid_rst_scale2", int'(scale_out), 9);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_scale", int'(scale_out), 10);
    check("post_rst_changed", int'(scale_changed), 1);
    btn_up = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
